// File: rtl/mips_defs.sv
// Shared definitions for the MIPS fetch unit and decode controller.
package mips_defs;

    // Byte address of ROM word 0 and PC value after reset
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUBU = 6'h23;

    // Fetch state encoding
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mips_npc.sv
// Next-PC selection (jr > jump > taken beq > pc+4) and ROM-range legality check.
module mips_npc
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_DEPTH = 1024
) (
    input  logic [31:0] pc_plus4_i,
    input  logic [25:0] target_i,
    input  logic [31:0] rs_val_i,
    input  logic        beq_i,
    input  logic        zero_i,
    input  logic        jump_i,
    input  logic        jr_i,
    output logic [31:0] npc_o,
    output logic        npc_legal_o
);

    // One past the last ROM byte, kept 33 bits wide so the bound never wraps
    localparam logic [32:0] ROM_END = {1'b0, PC_RESET} + 33'(IM_DEPTH) * 33'd4;

    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign br_off    = {{14{target_i[15]}}, target_i[15:0], 2'b00};
    assign br_target = pc_plus4_i + br_off;
    assign j_target  = {pc_plus4_i[31:28], target_i, 2'b00};

    // Priority mux over the controller's flow decisions
    always_comb begin
        npc_o = pc_plus4_i;
        if (jr_i)
            npc_o = rs_val_i;
        else if (jump_i)
            npc_o = j_target;
        else if (beq_i && zero_i)
            npc_o = br_target;
    end

    // Legal only if word aligned and inside the ROM window (unsigned compare)
    always_comb begin
        npc_legal_o = (npc_o[1:0] == 2'b00)
                   && (npc_o >= PC_RESET)
                   && ({1'b0, npc_o} < ROM_END);
    end

endmodule

// File: rtl/mips_ifu.sv
// Instruction fetch unit: PC, instruction ROM, boot/fault FSM, retired counter.
module mips_ifu
    import mips_defs::*;
#(
    parameter logic [31:0]             PC_RESET = PC_RESET_DEF,
    parameter int                      IM_DEPTH = 1024,
    parameter string                   IM_INIT  = "code.txt",
    // ROM contents as a flat image, word i at bits [32*i +: 32]; generated from IM_INIT
    parameter logic [IM_DEPTH*32-1:0]  IM_IMAGE = '0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        beq,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] rs_val,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] retired
);

    localparam int AW = $clog2(IM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  retired_q, retired_d;
    logic [AW-1:0] rom_idx;
    logic [31:0]  rom_word;
    logic [31:0]  npc;
    logic         npc_legal;
    logic         advance;

    // Combinational ROM read addressed by the word offset from PC_RESET
    assign rom_idx  = AW'((pc_q - PC_RESET) >> 2);
    assign rom_word = IM_IMAGE[{rom_idx, 5'b00000} +: 32];

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign retired  = retired_q;
    assign op       = instr[31:26];
    assign func     = instr[5:0];
    assign advance  = (state_q == ST_RUN) && en;

    mips_npc #(
        .PC_RESET (PC_RESET),
        .IM_DEPTH (IM_DEPTH)
    ) u_npc (
        .pc_plus4_i  (pc_plus4),
        .target_i    (instr[25:0]),
        .rs_val_i    (rs_val),
        .beq_i       (beq),
        .zero_i      (zero),
        .jump_i      (jump),
        .jr_i        (jr),
        .npc_o       (npc),
        .npc_legal_o (npc_legal)
    );

    // State, PC and counter registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= PC_RESET;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    // Next state: one settle cycle in BOOT, illegal npc on an advance traps in FAULT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (en && !npc_legal) state_d = ST_FAULT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // PC moves only on a legal advance; retired counts every advance, faulting one included
    always_comb begin
        pc_d      = pc_q;
        retired_d = retired_q;
        if (advance) begin
            retired_d = sat_inc32(retired_q);
            if (npc_legal)
                pc_d = npc;
        end
    end

    // FSM outputs: commit qualifier, sticky fault flag and instruction squash
    always_comb begin
        instr_valid = 1'b0;
        fault       = 1'b0;
        instr       = rom_word;
        case (state_q)
            ST_BOOT: ;
            ST_RUN:  instr_valid = en;
            default: begin
                fault = 1'b1;
                instr = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_ifu.sv
// Directed self-checking bench for mips_ifu with a small 32-word ROM image.
module tb_mips_ifu;

    localparam int DEPTH = 32;

    function automatic logic [DEPTH*32-1:0] mk_image();
        logic [DEPTH*32-1:0] img;
        img = '0;
        img[0*32  +: 32] = 32'h0800_0C10;  // 0x3000: j 0x0C10
        img[2*32  +: 32] = 32'h1000_FFFE;  // 0x3008: beq imm=-2
        img[16*32 +: 32] = 32'h2402_ABCD;  // 0x3040: addiu
        img[31*32 +: 32] = 32'h012A_4020;  // 0x307C: add (last word)
        return img;
    endfunction

    localparam logic [DEPTH*32-1:0] IMAGE = mk_image();

    logic        clk = 1'b0;
    logic        reset_n, en, beq, zero, jump, jr;
    logic [31:0] rs_val;
    logic [31:0] instr, pc, pc_plus4, retired;
    logic [5:0]  op, func;
    logic        instr_valid, fault;

    int checks   = 0;
    int failures = 0;

    mips_ifu #(
        .PC_RESET (32'h0000_3000),
        .IM_DEPTH (DEPTH),
        .IM_INIT  (""),
        .IM_IMAGE (IMAGE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .beq         (beq),
        .zero        (zero),
        .jump        (jump),
        .jr          (jr),
        .rs_val      (rs_val),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .fault       (fault),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic b, input logic z, input logic j, input logic r, input logic [31:0] rv);
        beq = b; zero = z; jump = j; jr = r; rs_val = rv;
    endtask

    // Apply reset between edges, release it, and pass the BOOT cycle
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        reset_n = 1'b1;
        chk("boot_valid", {31'd0, instr_valid}, 32'd0);
        step();
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1;
        ctl(0, 0, 0, 0, 32'h0);
        #12;
        // Asynchronous reset values
        chk("r_pc", pc, 32'h3000);
        chk("r_valid", {31'd0, instr_valid}, 32'd0);
        chk("r_fault", {31'd0, fault}, 32'd0);
        chk("r_retired", retired, 32'd0);
        step();
        reset_n = 1'b1;
        chk("boot_pc", pc, 32'h3000);
        chk("boot_valid", {31'd0, instr_valid}, 32'd0);
        step();
        // First RUN cycle
        chk("run_pc", pc, 32'h3000);
        chk("run_valid", {31'd0, instr_valid}, 32'd1);
        chk("run_instr", instr, 32'h0800_0C10);
        chk("run_op", {26'd0, op}, 32'h02);
        chk("run_func", {26'd0, func}, 32'h10);
        step();
        chk("seq_pc1", pc, 32'h3004);
        chk("seq_ret1", retired, 32'd1);
        step();
        chk("seq_pc2", pc, 32'h3008);
        chk("seq_ret2", retired, 32'd2);
        // Taken branch back to 0x3004
        ctl(1, 1, 0, 0, 32'h0);
        step();
        chk("beq_taken", pc, 32'h3004);
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("back_3008", pc, 32'h3008);
        chk("ret4", retired, 32'd4);
        // Stall three cycles
        en = 1'b0;
        #1;
        chk("stall_valid", {31'd0, instr_valid}, 32'd0);
        step(); step(); step();
        chk("stall_pc", pc, 32'h3008);
        chk("stall_ret", retired, 32'd4);
        chk("stall_valid2", {31'd0, instr_valid}, 32'd0);
        en = 1'b1;
        // Not-taken branch resumes sequentially
        ctl(1, 0, 0, 0, 32'h0);
        #1;
        chk("resume_valid", {31'd0, instr_valid}, 32'd1);
        step();
        chk("beq_nt", pc, 32'h300C);
        chk("ret5", retired, 32'd5);
        // jr back to 0x3000
        ctl(0, 0, 0, 1, 32'h3000);
        step();
        chk("jr_3000", pc, 32'h3000);
        // Jump wins over a taken branch
        ctl(1, 1, 1, 0, 32'h0);
        #1;
        chk("j_pc4", pc_plus4, 32'h3004);
        step();
        chk("jump_pc", pc, 32'h3040);
        chk("jump_instr", instr, 32'h2402_ABCD);
        chk("jump_op", {26'd0, op}, 32'h09);
        chk("jump_func", {26'd0, func}, 32'h0D);
        chk("ret7", retired, 32'd7);
        // jr wins over jump
        ctl(0, 0, 1, 1, 32'h3004);
        step();
        chk("jr_prio", pc, 32'h3004);
        // Last ROM word, then fall-through faults
        ctl(0, 0, 0, 1, 32'h307C);
        step();
        chk("last_pc", pc, 32'h307C);
        chk("last_func", {26'd0, func}, 32'h20);
        chk("last_ret", retired, 32'd9);
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("ft_pc", pc, 32'h307C);
        chk("ft_fault", {31'd0, fault}, 32'd1);
        chk("ft_instr", instr, 32'h0);
        chk("ft_op", {26'd0, op}, 32'h0);
        chk("ft_valid", {31'd0, instr_valid}, 32'd0);
        chk("ft_ret", retired, 32'd10);
        step();
        chk("sticky_fault", {31'd0, fault}, 32'd1);
        chk("sticky_ret", retired, 32'd10);
        chk("sticky_pc", pc, 32'h307C);

        // Misaligned jr target
        do_reset();
        ctl(0, 0, 0, 1, 32'h3002);
        step();
        chk("mis_pc", pc, 32'h3000);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_instr", instr, 32'h0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_ret", retired, 32'd1);

        // jr target below ROM; BOOT exits even with en=0
        ctl(0, 0, 0, 0, 32'h0);
        en = 1'b0;
        do_reset();
        chk("boot_en0_valid", {31'd0, instr_valid}, 32'd0);
        en = 1'b1;
        ctl(0, 0, 0, 1, 32'h2FFC);
        #1;
        chk("boot_en0_run", {31'd0, instr_valid}, 32'd1);
        step();
        chk("low_pc", pc, 32'h3000);
        chk("low_fault", {31'd0, fault}, 32'd1);
        chk("low_ret", retired, 32'd1);

        // Fault at 0x3040 (target one past ROM end), then async reset
        ctl(0, 0, 0, 0, 32'h0);
        do_reset();
        ctl(0, 0, 1, 0, 32'h0);
        step();
        chk("j2_pc", pc, 32'h3040);
        ctl(0, 0, 0, 1, 32'h3080);
        step();
        chk("end_pc", pc, 32'h3040);
        chk("end_fault", {31'd0, fault}, 32'd1);
        chk("end_ret", retired, 32'd2);
        ctl(0, 0, 0, 0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_pc", pc, 32'h3000);
        chk("ar_fault", {31'd0, fault}, 32'd0);
        chk("ar_ret", retired, 32'd0);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("ar_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_hold_pc", pc, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
